modmul_unit: RTL and testbench
==============================

Name: modmul_unit

Overview:
- Multi-cycle modular multiplier in the EX stage, directly downstream of the ID-stage register file.
- Consumes the two register read ports (rda/rdb) plus a modulus register value, and computes a*b mod m by interleaved shift-add, one multiplier bit per cycle.
- Produces a write-back request (result, destination register, write enable) that feeds the register-file write port.
- Primitive for RSA decryption (modular exponentiation loop in software).

Parameters:
N, 32, operand/result width in bits; iteration count.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-low reset (reset==0 clears state at rising edge)
start  in  1  request; sampled only when not busy
a  in  N  multiplicand (from rda)
b  in  N  multiplier (from rdb)
m  in  N  modulus
rd_in  in  5  destination register index
busy  out  1  high while computing
done  out  1  one-cycle pulse, result valid
we_out  out  1  register write enable; equals done
rd_out  out  5  destination index latched at start
result  out  N  a*b mod m
err  out  1  latched with done; 1 = invalid operands

Behaviour:
- Clock and reset: one clock domain, clk. Synchronous active-low reset. reset==0 at a rising edge sets:
  - state to IDLE
  - busy=0, done=0, we_out=0, err=0
  - result=0, rd_out=0
  - internal accumulator, bit counter and operand registers to 0
- Reset wins over every other input, including mid-computation. The aborted operation never produces done.
- States:
  - IDLE: busy=0. If start=1, latch a, b, m, rd_in, clear accumulator R and counter, then check operands.
    - If m==0, a>=m, or b>=m: go to FIN with err=1 and result 0.
    - Otherwise go to RUN.
  - RUN: busy=1. Iteration i runs from N-1 down to 0. Each cycle:
    - R=2R; if R>=m then R-=m
    - if b[i] then R+=a; if R>=m then R-=m
    - After the iteration with i==0, go to FIN.
  - FIN: for exactly one cycle, done=1 and we_out=1; result=R (or 0 if err); rd_out=latched rd_in; busy=0. Next state is IDLE, or RUN/FIN if start=1 in this cycle (back-to-back accepted).
- Latency:
  - start accepted in cycle t → RUN in cycles t+1 … t+N → done high in cycle t+N+1.
  - Error fast path: done in cycle t+1.
- Width rules:
  - Invariant R<m holds before each iteration.
  - 2R and R+a are below 2m, so the datapath is N+1 bits wide. No overflow for any N-bit m.
  - Inputs are treated as unsigned.
- Output holding:
  - result, rd_out and err hold their values after done until the next FIN.
  - done and we_out are single-cycle pulses.
- start while busy (RUN) is ignored and not queued. Operand inputs may change freely during RUN.
- Output changes come only from registered state; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset: reset=0 for 2 cycles with start=1 → busy=0, done=0, we_out=0, result=0, err=0, rd_out=0.
2. Basic: N=32, a=7, b=5, m=13, rd_in=3, start for 1 cycle at t → busy=1 during t+1..t+32; done=we_out=1 only at t+33; result=9, rd_out=3, err=0.
3. Wide: a=b=0xFFFFFFFE, m=0xFFFFFFFF → result=1 after 33 cycles. a=0x12345678, b=0x9ABCDEF0, m=0xFFFFFFFB → result equals the reference-model (a*b)%m.
4. Errors: m=0 → done at t+1, err=1, result=0. a=20, b=3, m=13 → done at t+1, err=1. A following valid op (7,5,13) → err=0, result=9.
5. Busy/back-to-back: pulse start again at t+10 with a=2 → ignored, result=9. Assert start in FIN cycle t+33 with 2,3,13 → busy from t+34, done at t+66, result=6.
6. Reset mid-op: reset=0 at t+15 → no done pulse. State is IDLE. New start at t+17 completes normally at t+50.

Source files
------------

// File: rtl/modmul_unit.sv
// Multi-cycle modular multiplier for the EX stage.
// Computes result = a*b mod m by interleaved shift-add, scanning the multiplier
// from its MSB, one bit per clock. Invalid operands (m==0, a>=m or b>=m) take a
// one-cycle fast path that reports err=1 with a zero result. The write-back
// request (result, rd_out, we_out) feeds the register-file write port directly.
module modmul_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] m,
    input  logic [4:0]   rd_in,
    output logic         busy,
    output logic         done,
    output logic         we_out,
    output logic [4:0]   rd_out,
    output logic [N-1:0] result,
    output logic         err
);

    // Width of the iteration counter; it counts 0 .. N-1.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t         state_reg;

    // Operand registers captured when a request is accepted. The multiplier
    // is kept as a left-shifting copy so the current bit is always the MSB.
    logic [N-1:0]   a_reg;
    logic [N-1:0]   m_reg;
    logic [N-1:0]   b_shift_reg;
    logic [4:0]     rd_lat_reg;

    // Running remainder; invariant acc_reg < m_reg before every iteration.
    logic [N-1:0]   acc_reg;
    logic [CW-1:0]  cnt_reg;

    // Registered outputs.
    logic           busy_reg;
    logic           done_reg;
    logic           err_reg;
    logic [N-1:0]   result_reg;
    logic [4:0]     rd_out_reg;

    // One-iteration datapath. Every intermediate is strictly below 2m, so one
    // extra bit of headroom is enough for any N-bit modulus.
    logic [N:0]     dbl_wide;
    logic [N:0]     dbl_red;
    logic [N:0]     sum_wide;
    logic           sum_ge_m;
    logic [N-1:0]   acc_next;
    logic [N:0]     m_wide;

    // Operand validity check on the live inputs, used when accepting a request.
    logic           start_err;
    logic           accept;

    // Combinational step: R = 2R mod m, then (R + a*bit) mod m.
    always_comb begin
        m_wide   = {1'b0, m_reg};
        dbl_wide = {acc_reg, 1'b0};
        dbl_red  = (dbl_wide >= m_wide) ? (dbl_wide - m_wide) : dbl_wide;
        sum_wide = b_shift_reg[N-1] ? (dbl_red + {1'b0, a_reg}) : dbl_red;
        sum_ge_m = (sum_wide >= m_wide);
        acc_next = sum_ge_m ? N'(sum_wide - m_wide) : sum_wide[N-1:0];
    end

    // Request qualification: accepted whenever the unit is not iterating.
    always_comb begin
        start_err = (m == '0) || (a >= m) || (b >= m);
        accept    = start && (state_reg != RUN);
    end

    // Control FSM with registered outputs and operand/accumulator state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            m_reg       <= '0;
            b_shift_reg <= '0;
            rd_lat_reg  <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            result_reg  <= '0;
            rd_out_reg  <= '0;
        end else begin
            // done is a single-cycle pulse unless re-armed below.
            done_reg <= 1'b0;

            case (state_reg)
                IDLE, FIN: begin
                    busy_reg <= 1'b0;
                    if (accept) begin
                        a_reg       <= a;
                        m_reg       <= m;
                        b_shift_reg <= b;
                        rd_lat_reg  <= rd_in;
                        acc_reg     <= '0;
                        cnt_reg     <= '0;
                        if (start_err) begin
                            // Fast path: report the bad operands next cycle.
                            state_reg  <= FIN;
                            done_reg   <= 1'b1;
                            err_reg    <= 1'b1;
                            result_reg <= '0;
                            rd_out_reg <= rd_in;
                        end else begin
                            state_reg <= RUN;
                            busy_reg  <= 1'b1;
                        end
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                RUN: begin
                    acc_reg     <= acc_next;
                    b_shift_reg <= b_shift_reg << 1;
                    cnt_reg     <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ITER) begin
                        // Last multiplier bit consumed: publish the write-back.
                        state_reg  <= FIN;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        err_reg    <= 1'b0;
                        result_reg <= acc_next;
                        rd_out_reg <= rd_lat_reg;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign we_out = done_reg;
    assign err    = err_reg;
    assign result = result_reg;
    assign rd_out = rd_out_reg;

endmodule

// File: tb/tb_modmul_unit.sv
// Self-checking bench for modmul_unit: directed scenarios plus randomized
// operations compared against a plain-arithmetic reference of a*b mod m.
module tb_modmul_unit;

    localparam int N = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] m;
    logic [4:0]   rd_in;
    logic         busy;
    logic         done;
    logic         we_out;
    logic [4:0]   rd_out;
    logic [N-1:0] result;
    logic         err;

    int n_checks;
    int n_errors;

    modmul_unit #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .m      (m),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .we_out (we_out),
        .rd_out (rd_out),
        .result (result),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: validity rule and a*b mod m using 64-bit integer arithmetic.
    function automatic void ref_model(input logic [31:0] ra, input logic [31:0] rb,
                                      input logic [31:0] rm, output logic rerr,
                                      output logic [31:0] rres);
        longint unsigned prod;
        rerr = (rm == 0) || (ra >= rm) || (rb >= rm);
        if (rerr) begin
            rres = '0;
        end else begin
            prod = longint'(ra) * longint'(rb);
            rres = 32'(prod % longint'(rm));
        end
    endfunction

    // One complete operation from IDLE: latency, busy span, write-back fields,
    // single-cycle done and output holding are all checked.
    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic [31:0] tm, input logic [4:0] trd);
        logic        exp_err;
        logic [31:0] exp_res;
        int          lat;
        int          busy_cnt;
        int          exp_lat;
        int          exp_busy;
        ref_model(ta, tb_, tm, exp_err, exp_res);
        exp_lat  = exp_err ? 1 : N + 1;
        exp_busy = exp_err ? 0 : N;
        a = ta; b = tb_; m = tm; rd_in = trd; start = 1'b1;
        step();
        start = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int c = 1; c <= N + 4; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                lat = c;
                break;
            end
            // Operand inputs are free to change while the unit iterates.
            a = $urandom; b = $urandom; m = $urandom; rd_in = 5'($urandom);
            step();
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        chk({tag, "_result"}, 64'(result), 64'(exp_res));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        chk({tag, "_rd_out"}, 64'(rd_out), 64'(trd));
        chk({tag, "_we_out"}, 64'(we_out), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        $display("op %s a=%08h b=%08h m=%08h rd=%0d -> result=%08h err=%0d lat=%0d",
                 tag, ta, tb_, tm, trd, result, err, lat);
        step();
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_we_pulse"}, 64'(we_out), 64'd0);
        chk({tag, "_result_hold"}, 64'(result), 64'(exp_res));
        chk({tag, "_err_hold"}, 64'(err), 64'(exp_err));
    endtask

    initial begin
        int          c;
        logic        saw_done;
        logic        e_err;
        logic [31:0] e_res;
        logic [31:0] ra, rb, rm;

        n_checks = 0;
        n_errors = 0;

        // Reset held for two cycles with start asserted.
        reset = 1'b0; start = 1'b1;
        a = 32'd7; b = 32'd5; m = 32'd13; rd_in = 5'd9;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_we", 64'(we_out), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rd_out", 64'(rd_out), 64'd0);
        start = 1'b0;
        reset = 1'b1;
        step();
        chk("rst_idle_busy", 64'(busy), 64'd0);

        // Basic and wide-operand cases.
        do_op("basic", 32'd7, 32'd5, 32'd13, 5'd3);
        chk("basic_const", 64'(result), 64'd9);
        do_op("wide1", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd31);
        chk("wide1_const", 64'(result), 64'd1);
        do_op("wide2", 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFB, 5'd17);

        // Operand errors, then a valid operation clears err.
        do_op("err_m0", 32'd7, 32'd5, 32'd0, 5'd4);
        do_op("err_a_ge_m", 32'd20, 32'd3, 32'd13, 5'd5);
        do_op("after_err", 32'd7, 32'd5, 32'd13, 5'd6);
        chk("after_err_const", 64'(result), 64'd9);

        // Start during RUN is ignored; start in the FIN cycle is accepted.
        a = 32'd7; b = 32'd5; m = 32'd13; rd_in = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        c = 1;
        while (c <= 40 && !done) begin
            if (c == 10) begin
                start = 1'b1; a = 32'd2;
            end else if (c == 11) begin
                start = 1'b0;
            end
            step();
            c++;
        end
        chk("b2b_first_lat", 64'(c), 64'd33);
        chk("b2b_first_result", 64'(result), 64'd9);
        chk("b2b_first_rd", 64'(rd_out), 64'd3);
        a = 32'd2; b = 32'd3; m = 32'd13; rd_in = 5'd4; start = 1'b1;
        step();
        start = 1'b0;
        c = 34;
        chk("b2b_second_busy", 64'(busy), 64'd1);
        chk("b2b_second_done_low", 64'(done), 64'd0);
        while (c <= 80 && !done) begin
            step();
            c++;
        end
        chk("b2b_second_lat", 64'(c), 64'd66);
        chk("b2b_second_result", 64'(result), 64'd6);
        chk("b2b_second_rd", 64'(rd_out), 64'd4);
        $display("op b2b second result=%08h done_cycle=%0d", result, c);
        step();

        // Reset mid-operation aborts without a done pulse.
        a = 32'd7; b = 32'd5; m = 32'd13; rd_in = 5'd8; start = 1'b1;
        step();
        start = 1'b0;
        saw_done = 1'b0;
        for (c = 1; c < 15; c++) begin
            if (done) saw_done = 1'b1;
            step();
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        c = 16;
        if (done) saw_done = 1'b1;
        chk("midrst_no_done", 64'(saw_done), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        chk("midrst_rd_out", 64'(rd_out), 64'd0);
        step();
        c = 17;
        a = 32'd7; b = 32'd5; m = 32'd13; rd_in = 5'd12; start = 1'b1;
        step();
        start = 1'b0;
        c = 18;
        while (c <= 70 && !done) begin
            step();
            c++;
        end
        chk("midrst_new_lat", 64'(c), 64'd50);
        chk("midrst_new_result", 64'(result), 64'd9);
        chk("midrst_new_rd", 64'(rd_out), 64'd12);
        $display("op midrst restart result=%08h done_cycle=%0d", result, c);
        step();

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 7))
                0: rm = 32'd0;
                1, 2: rm = $urandom_range(1, 100);
                default: rm = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                ra = $urandom; rb = $urandom;
            end else if (rm != 0) begin
                ra = $urandom % rm; rb = $urandom % rm;
            end else begin
                ra = $urandom; rb = $urandom;
            end
            ref_model(ra, rb, rm, e_err, e_res);
            do_op($sformatf("rnd%0d", i), ra, rb, rm, 5'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
